// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    S_UP,
    S_DOWN_CHK,
    S_DOWN,
    S_UP_CHK
  } key_state_e;

  localparam int unsigned DEB_CYCLES_DEF = 1000000;
  localparam int unsigned NUM_KEYS_DEF   = 4;

endpackage

// File: rtl/key_debounce_1ch.sv
// One key channel: 2-FF synchroniser, debounce FSM with stable-time counter,
// registered level plus single-cycle press/release pulses.
module key_debounce_1ch
  import key_cond_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("key_debounce_1ch: DEB_CYCLES must be >= 2");
  end

  logic             sync1_q;
  logic             sync2_q;
  key_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;

  // Sync flops reset to 1 so a released key is seen as released out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_UP;
      cnt_q           <= '0;
      o_pressed       <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
    end else begin
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      unique case (state_q)
        S_UP: begin
          if (!sync2_q) begin
            state_q <= S_DOWN_CHK;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        S_DOWN_CHK: begin
          if (sync2_q) begin
            state_q <= S_UP;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q       <= S_DOWN;
            cnt_q         <= '0;
            o_pressed     <= 1'b1;
            o_press_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DOWN: begin
          if (sync2_q) begin
            state_q <= S_UP_CHK;
            cnt_q   <= CNT_W'(1);
          end
        end
        S_UP_CHK: begin
          // A pressed sample here is a release bounce; level never dropped.
          if (!sync2_q) begin
            state_q <= S_DOWN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q         <= S_UP;
            cnt_q           <= '0;
            o_pressed       <= 1'b0;
            o_release_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_UP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS active-low bouncy push-buttons into clean levels and
// single-cycle press/release pulses; channels are fully independent.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_pressed,
  output logic [NUM_KEYS-1:0] o_press_pulse,
  output logic [NUM_KEYS-1:0] o_release_pulse
);

  if (NUM_KEYS < 1) begin : g_bad_num
    $error("key_conditioner: NUM_KEYS must be >= 1");
  end

  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : g_ch
    key_debounce_1ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_key_n        (i_key_n[k]),
      .o_pressed      (o_pressed[k]),
      .o_press_pulse  (o_press_pulse[k]),
      .o_release_pulse(o_release_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench: directed literal checks plus randomized bouncing keys
// compared every cycle against a sliding-window behavioural model.
module tb_key_conditioner;

  localparam int NK  = 3;
  localparam int DEB = 4;

  logic          i_clk;
  logic          i_rst_n;
  logic [NK-1:0] i_key_n;
  logic [NK-1:0] o_pressed;
  logic [NK-1:0] o_press_pulse;
  logic [NK-1:0] o_release_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  key_conditioner #(
    .NUM_KEYS  (NK),
    .DEB_CYCLES(DEB)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_key_n        (i_key_n),
    .o_pressed      (o_pressed),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model: raw pin delayed by two flops; the level flips once the last DEB
  // samples seen are all opposite to the current level.
  logic [NK-1:0]          m_ff1, m_ff2;
  logic [NK-1:0][DEB-1:0] m_hist, m_hist_n;
  logic [NK-1:0]          m_level, m_level_n;
  logic [NK-1:0]          m_press, m_press_n;
  logic [NK-1:0]          m_rel, m_rel_n;

  always_comb begin
    m_hist_n  = m_hist;
    m_level_n = m_level;
    m_press_n = '0;
    m_rel_n   = '0;
    for (int k = 0; k < NK; k++) begin
      m_hist_n[k] = {m_hist[k][DEB-2:0], m_ff2[k]};
      if (!m_level[k] && m_hist_n[k] == '0) begin
        m_level_n[k] = 1'b1;
        m_press_n[k] = 1'b1;
      end else if (m_level[k] && m_hist_n[k] == {DEB{1'b1}}) begin
        m_level_n[k] = 1'b0;
        m_rel_n[k]   = 1'b1;
      end
    end
  end

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_ff1   <= '1;
      m_ff2   <= '1;
      m_hist  <= '1;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
    end else begin
      m_ff1   <= i_key_n;
      m_ff2   <= m_ff1;
      m_hist  <= m_hist_n;
      m_level <= m_level_n;
      m_press <= m_press_n;
      m_rel   <= m_rel_n;
    end
  end

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  always begin
    @(posedge i_clk);
    #1;
    check("model_pressed", o_pressed, m_level);
    check("model_press_pulse", o_press_pulse, m_press);
    check("model_release_pulse", o_release_pulse, m_rel);
    check("pulse_overlap", o_press_pulse & o_release_pulse, '0);
  end

  initial begin
    i_rst_n = 1'b0;
    i_key_n = '1;
    step(3);
    i_rst_n = 1'b1;

    step(20);
    check("idle_pressed", o_pressed, 3'b000);
    check("idle_press_pulse", o_press_pulse, 3'b000);
    check("idle_release_pulse", o_release_pulse, 3'b000);

    // Key0 press, first sampled at edge 0.
    i_key_n = 3'b110;
    step(5);
    check("press_e4_pressed", o_pressed, 3'b000);
    check("press_e4_pulse", o_press_pulse, 3'b000);
    step(1);
    check("press_e5_pressed", o_pressed, 3'b001);
    check("press_e5_pulse", o_press_pulse, 3'b001);
    step(1);
    check("press_e6_pressed", o_pressed, 3'b001);
    check("press_e6_pulse", o_press_pulse, 3'b000);

    // Key1 bounce of 3 low cycles is rejected.
    i_key_n = 3'b100;
    step(3);
    i_key_n = 3'b110;
    step(10);
    check("bounce3_pressed", o_pressed, 3'b001);

    // Key1 low for exactly 4 cycles is accepted.
    i_key_n = 3'b100;
    step(4);
    i_key_n = 3'b110;
    step(1);
    check("bounce4_e4_pulse", o_press_pulse, 3'b000);
    step(1);
    check("bounce4_e5_pulse", o_press_pulse, 3'b010);
    step(12);
    check("bounce4_settled", o_pressed, 3'b001);

    // Key0 release glitch of 2 cycles, then a real release.
    i_key_n = 3'b111;
    step(2);
    i_key_n = 3'b110;
    step(10);
    check("rel_glitch_pressed", o_pressed, 3'b001);
    i_key_n = 3'b111;
    step(5);
    check("rel_e4_pressed", o_pressed, 3'b001);
    check("rel_e4_pulse", o_release_pulse, 3'b000);
    step(1);
    check("rel_e5_pressed", o_pressed, 3'b000);
    check("rel_e5_pulse", o_release_pulse, 3'b001);
    step(1);
    check("rel_e6_pulse", o_release_pulse, 3'b000);

    // Keys 0 and 2 together.
    i_key_n = 3'b010;
    step(5);
    check("simul_e4_pulse", o_press_pulse, 3'b000);
    step(1);
    check("simul_e5_pulse", o_press_pulse, 3'b101);
    check("simul_e5_pressed", o_pressed, 3'b101);

    // Reset while key1 is mid-check; all keys stay held through reset.
    i_key_n = 3'b000;
    step(3);
    i_rst_n = 1'b0;
    #1;
    check("rst_pressed", o_pressed, 3'b000);
    check("rst_press_pulse", o_press_pulse, 3'b000);
    check("rst_release_pulse", o_release_pulse, 3'b000);
    step(2);
    i_rst_n = 1'b1;
    step(5);
    check("postrst_e4_pressed", o_pressed, 3'b000);
    step(1);
    check("postrst_e5_pulse", o_press_pulse, 3'b111);
    check("postrst_e5_pressed", o_pressed, 3'b111);

    // Random bouncing keys with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge i_clk);
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 5) == 0) i_key_n[k] = ~i_key_n[k];
      end
      if ($urandom_range(0, 799) == 0) begin
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
      end
    end
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
